pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Central pipeline sequencer for the RV32I core. Every cycle it produces the `stall_n`/`flush` pairs for the PC register, IF_ID, ID_EX and EX_MEM, and the PC source select. It resolves load-use hazards, taken branches and jumps, late-stage exceptions and data-memory wait states. It also runs a small refill FSM that covers the extra instruction-return cycle when fetch data is delayed one tick.

## Interface
Parameters:
- `FETCH_LATENCY`, default 1. Value 1 means the instruction arrives one cycle after its address (matching IF_ID with 1-tick delay). Value 0 means the instruction arrives in the same cycle.

Ports (name, direction, width, meaning):
- `clk`, in, 1: core clock; all state changes on posedge.
- `rst_sync_n`, in, 1: reset, synchronous, active-low.
- `id_rs1`, `id_rs2`, in, 5 each: source register indices of the instruction in ID.
- `id_rs1_used`, `id_rs2_used`, in, 1 each: the ID instruction actually reads that source.
- `ex_rd`, in, 5: destination register of the instruction in EX.
- `ex_is_load`, in, 1: the instruction in EX is a load.
- `redirect_ex`, in, 1: a branch or jump taken in EX.
- `exception_raise`, in, 1: an exception or interrupt committed at MEM; trap entry is required.
- `mem_wait`, in, 1: the data bus is not ready; the whole pipeline must freeze.
- `pc_stall_n`, `if_id_stall_n`, `id_ex_stall_n`, `ex_mem_stall_n`, out, 1 each: the stage loads when 1.
- `if_id_flush`, `id_ex_flush`, `ex_mem_flush`, out, 1 each: the stage loads a NOP or bubble.
- `pc_src`, out, 2: next-PC select, of type `pc_src_e`.
- `bubble_cnt`, out, 32: count of cycles in which any flush output was 1. Wraps modulo 2^32.

## Operation
- FSM states are `RUN` and `REFILL`. All outputs are combinational from the current state and current inputs. The only registered elements are the state and `bubble_cnt`.
- The cases below are evaluated in strict priority order; the first match wins.
- **Reset** (`rst_sync_n`=0):
  - Every flush output is 1 and every stall_n output is 1.
  - `pc_src` = `PC_SEQ`.
  - Next state is `RUN`; `bubble_cnt` is loaded with 0 (no increment in reset cycles).
- **Trap** (`exception_raise`=1, in any state, even when `mem_wait`=1):
  - `pc_src` = `PC_TRAP`.
  - `if_id_flush`, `id_ex_flush` and `ex_mem_flush` are all 1; all stall_n are 1.
  - Next state is `REFILL` if `FETCH_LATENCY`=1, otherwise `RUN`.
- **Memory wait** (`mem_wait`=1):
  - All stall_n are 0 and all flushes are 0.
  - `pc_src` = `PC_SEQ`.
  - State is held, so a pending `REFILL` is resumed after the wait ends.
  - `redirect_ex` and the load-use check are deferred; they are re-evaluated once the frozen inputs are released.
- **Redirect** (`redirect_ex`=1):
  - `pc_src` = `PC_BRANCH`.
  - `if_id_flush` and `id_ex_flush` are 1; all stall_n are 1.
  - Next state is `REFILL` if `FETCH_LATENCY`=1, otherwise `RUN`.
- **REFILL state** (no higher-priority event):
  - `if_id_flush`=1, so the stale instruction returning from the old PC is discarded.
  - All other flushes are 0; all stall_n are 1; `pc_src` = `PC_SEQ`.
  - Next state is `RUN`.
- **Load-use hazard** (state `RUN`):
  - Condition: `ex_is_load` && `ex_rd`≠0 && ((`id_rs1_used` && `id_rs1`==`ex_rd`) || (`id_rs2_used` && `id_rs2`==`ex_rd`)).
  - Response: `pc_stall_n`=0, `if_id_stall_n`=0, `id_ex_flush`=1. `id_ex_stall_n` and `ex_mem_stall_n` stay 1.
- **Default:** all stall_n are 1, all flushes are 0, `pc_src` = `PC_SEQ`.
- A flush overrides its stage's stall_n inside each pipeline register, so the controller never drives flush=1 with stall_n=0 on the same stage.
- Register x0 never creates a hazard.

## Timing
- Hazard, redirect and trap responses are zero-latency: they act on the same cycle's inputs.
- State changes take effect at the next posedge.
- The redirect penalty is 2 bubbles with `FETCH_LATENCY`=0 and 3 bubbles with `FETCH_LATENCY`=1.
- The load-use penalty is 1 bubble, repeated every cycle while the condition holds.
- If `redirect_ex` and a load-use hazard occur in the same cycle, the redirect wins and no stall is applied.
- `bubble_cnt` updates at the posedge after each qualifying cycle.
- If reset is asserted mid-REFILL, the FSM returns to `RUN` with no further refill flush.

## Structure
- A shared package `Pipeline_Ctrl_Pkg` holds:
  - `pc_src_e` (2 bits): `PC_SEQ`=0, `PC_BRANCH`=1, `PC_TRAP`=2; value 3 is reserved and never driven.
  - `ctrl_state_e`: `RUN` and `REFILL`.
- One sub-module, `hazard_detect`, is natural: the purely combinational load-use compare, producing a single `load_use` output.

## Test plan
- Load-use: `ex_is_load`=1, `ex_rd`=5, `id_rs1`=5, `id_rs1_used`=1 → `pc_stall_n`=0, `if_id_stall_n`=0, `id_ex_flush`=1. Repeat the same stimulus with `ex_rd`=0 → no stall and no flush.
- Redirect with `FETCH_LATENCY`=1: pulse `redirect_ex` for one cycle.
  - Cycle 0: `pc_src`=1, `if_id_flush`=1 and `id_ex_flush`=1.
  - Cycle 1: only `if_id_flush`=1.
  - Cycle 2: no flush.
  - `bubble_cnt` has increased by 2.
- Trap during `mem_wait`: `exception_raise`=1 and `mem_wait`=1 → `pc_src`=2, all three flushes are 1, all stall_n are 1.
- `mem_wait` arriving in `REFILL`:
  - While `mem_wait`=1 for 3 cycles: all stall_n=0 and all flushes=0.
  - First cycle after `mem_wait` drops: `if_id_flush`=1, then the FSM returns to `RUN`.
- Simultaneous `redirect_ex` and load-use → `pc_src`=1, `pc_stall_n`=1, `if_id_flush`=1 and `id_ex_flush`=1.
- Reset asserted for 2 cycles during `REFILL` → all flushes are 1 and `bubble_cnt`=0. After release, the first cycle drives defaults: no flush and `pc_src`=0.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and widths for the pipeline sequencer.
package Pipeline_Ctrl_Pkg;

  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned CNT_W     = 32;

  // Next-PC select; encoding 3 is reserved and never driven.
  typedef enum logic [1:0] {
    PC_SEQ    = 2'd0,
    PC_BRANCH = 2'd1,
    PC_TRAP   = 2'd2
  } pc_src_e;

  // RUN: normal flow. REFILL: one extra cycle discarding the stale fetch return.
  typedef enum logic {
    RUN    = 1'b0,
    REFILL = 1'b1
  } ctrl_state_e;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard compare between the load in EX and the sources read in ID.
module hazard_detect
  import Pipeline_Ctrl_Pkg::*;
(
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_rs1_used,
  input  logic                 id_rs2_used,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic                 ex_is_load,
  output logic                 load_use
);

  logic rd_nonzero;
  logic rs1_hit;
  logic rs2_hit;

  // x0 is hardwired to zero, so it can never be the target of a real dependency.
  always_comb begin
    rd_nonzero = (ex_rd != REG_IDX_W'(0));
    rs1_hit    = id_rs1_used && (id_rs1 == ex_rd);
    rs2_hit    = id_rs2_used && (id_rs2 == ex_rd);
    load_use   = ex_is_load && rd_nonzero && (rs1_hit || rs2_hit);
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central pipeline sequencer: stall/flush per stage, PC source select,
// refill tracking for delayed fetch returns and a bubble counter.
module pipeline_ctrl
  import Pipeline_Ctrl_Pkg::*;
#(
  parameter int unsigned FETCH_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 rst_sync_n,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_rs1_used,
  input  logic                 id_rs2_used,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic                 ex_is_load,
  input  logic                 redirect_ex,
  input  logic                 exception_raise,
  input  logic                 mem_wait,
  output logic                 pc_stall_n,
  output logic                 if_id_stall_n,
  output logic                 id_ex_stall_n,
  output logic                 ex_mem_stall_n,
  output logic                 if_id_flush,
  output logic                 id_ex_flush,
  output logic                 ex_mem_flush,
  output pc_src_e              pc_src,
  output logic [CNT_W-1:0]     bubble_cnt
);

  // With a one-tick fetch, the instruction from the old PC still returns once after a redirect.
  localparam ctrl_state_e REDIRECT_TGT = (FETCH_LATENCY == 1) ? REFILL : RUN;

  ctrl_state_e      state_q, state_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
  logic             load_use;
  logic             any_flush;

  hazard_detect u_hazard_detect (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rs1_used (id_rs1_used),
    .id_rs2_used (id_rs2_used),
    .ex_rd       (ex_rd),
    .ex_is_load  (ex_is_load),
    .load_use    (load_use)
  );

  // State and bubble counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_sync_n) begin
      state_q      <= RUN;
      bubble_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  // Prioritised next-state and stage control: reset, trap, mem wait, redirect, refill, load-use.
  always_comb begin
    state_d        = state_q;
    pc_stall_n     = 1'b1;
    if_id_stall_n  = 1'b1;
    id_ex_stall_n  = 1'b1;
    ex_mem_stall_n = 1'b1;
    if_id_flush    = 1'b0;
    id_ex_flush    = 1'b0;
    ex_mem_flush   = 1'b0;
    pc_src         = PC_SEQ;

    if (!rst_sync_n) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      state_d      = RUN;
    end else if (exception_raise) begin
      pc_src       = PC_TRAP;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      state_d      = REDIRECT_TGT;
    end else if (mem_wait) begin
      // Freeze everything; state is held so a pending refill resumes afterwards.
      pc_stall_n     = 1'b0;
      if_id_stall_n  = 1'b0;
      id_ex_stall_n  = 1'b0;
      ex_mem_stall_n = 1'b0;
    end else if (redirect_ex) begin
      pc_src      = PC_BRANCH;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      state_d     = REDIRECT_TGT;
    end else if (state_q == REFILL) begin
      if_id_flush = 1'b1;
      state_d     = RUN;
    end else if (load_use) begin
      pc_stall_n    = 1'b0;
      if_id_stall_n = 1'b0;
      id_ex_flush   = 1'b1;
    end
  end

  // Count non-reset cycles in which any stage is flushed.
  always_comb begin
    any_flush    = if_id_flush || id_ex_flush || ex_mem_flush;
    bubble_cnt_d = bubble_cnt_q + CNT_W'(any_flush);
  end

  assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: two instances (fetch latency 1 and 0) on shared stimulus,
// a rule-level model checked every cycle, plus hand-computed literal checks.
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst_sync_n;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_rs1_used, id_rs2_used, ex_is_load;
  logic        redirect_ex, exception_raise, mem_wait;

  logic        pc_stall_n_1, if_id_stall_n_1, id_ex_stall_n_1, ex_mem_stall_n_1;
  logic        if_id_flush_1, id_ex_flush_1, ex_mem_flush_1;
  logic [1:0]  pc_src_1;
  logic [31:0] bubble_cnt_1;

  logic        pc_stall_n_0, if_id_stall_n_0, id_ex_stall_n_0, ex_mem_stall_n_0;
  logic        if_id_flush_0, id_ex_flush_0, ex_mem_flush_0;
  logic [1:0]  pc_src_0;
  logic [31:0] bubble_cnt_0;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Model state per instance: index 0 = latency 0, index 1 = latency 1.
  int          refill_left [2] = '{0, 0};
  logic [31:0] m_cnt       [2] = '{32'd0, 32'd0};
  logic [31:0] base;

  always #5 clk = ~clk;

  pipeline_ctrl #(.FETCH_LATENCY(1)) dut1 (
    .clk(clk), .rst_sync_n(rst_sync_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_rd(ex_rd), .ex_is_load(ex_is_load), .redirect_ex(redirect_ex),
    .exception_raise(exception_raise), .mem_wait(mem_wait),
    .pc_stall_n(pc_stall_n_1), .if_id_stall_n(if_id_stall_n_1),
    .id_ex_stall_n(id_ex_stall_n_1), .ex_mem_stall_n(ex_mem_stall_n_1),
    .if_id_flush(if_id_flush_1), .id_ex_flush(id_ex_flush_1), .ex_mem_flush(ex_mem_flush_1),
    .pc_src(pc_src_1), .bubble_cnt(bubble_cnt_1)
  );

  pipeline_ctrl #(.FETCH_LATENCY(0)) dut0 (
    .clk(clk), .rst_sync_n(rst_sync_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_rd(ex_rd), .ex_is_load(ex_is_load), .redirect_ex(redirect_ex),
    .exception_raise(exception_raise), .mem_wait(mem_wait),
    .pc_stall_n(pc_stall_n_0), .if_id_stall_n(if_id_stall_n_0),
    .id_ex_stall_n(id_ex_stall_n_0), .ex_mem_stall_n(ex_mem_stall_n_0),
    .if_id_flush(if_id_flush_0), .id_ex_flush(id_ex_flush_0), .ex_mem_flush(ex_mem_flush_0),
    .pc_src(pc_src_0), .bubble_cnt(bubble_cnt_0)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected {pc,if_id,id_ex,ex_mem stall_n, if_id,id_ex,ex_mem flush, pc_src} from the rules.
  function automatic logic [8:0] model_vec(input int refills);
    bit hit;
    hit = ex_is_load && (ex_rd != 5'd0) &&
          ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd));
    if (!rst_sync_n)     return {4'b1111, 3'b111, 2'd0};
    if (exception_raise) return {4'b1111, 3'b111, 2'd2};
    if (mem_wait)        return {4'b0000, 3'b000, 2'd0};
    if (redirect_ex)     return {4'b1111, 3'b110, 2'd1};
    if (refills > 0)     return {4'b1111, 3'b100, 2'd0};
    if (hit)             return {4'b0011, 3'b010, 2'd0};
    return {4'b1111, 3'b000, 2'd0};
  endfunction

  // Every-cycle comparison of both instances against the model, then model advance.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        logic [8:0]  exp_v;
        logic [8:0]  act_v;
        logic [31:0] act_c;
        exp_v = model_vec(refill_left[i]);
        if (i == 1) begin
          act_v = {pc_stall_n_1, if_id_stall_n_1, id_ex_stall_n_1, ex_mem_stall_n_1,
                   if_id_flush_1, id_ex_flush_1, ex_mem_flush_1, pc_src_1};
          act_c = bubble_cnt_1;
        end else begin
          act_v = {pc_stall_n_0, if_id_stall_n_0, id_ex_stall_n_0, ex_mem_stall_n_0,
                   if_id_flush_0, id_ex_flush_0, ex_mem_flush_0, pc_src_0};
          act_c = bubble_cnt_0;
        end
        check($sformatf("model_outputs_lat%0d", i), 32'(act_v), 32'(exp_v));
        check($sformatf("model_bubble_cnt_lat%0d", i), act_c, m_cnt[i]);
        if (!rst_sync_n) begin
          refill_left[i] = 0;
          m_cnt[i]       = 32'd0;
        end else begin
          if (exp_v[4:2] != 3'b000) m_cnt[i] = m_cnt[i] + 32'd1;
          if (exception_raise || (!mem_wait && redirect_ex)) refill_left[i] = i;
          else if (!mem_wait && refill_left[i] > 0) refill_left[i] = refill_left[i] - 1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    id_rs1_used = 1'b0; id_rs2_used = 1'b0; ex_is_load = 1'b0;
    redirect_ex = 1'b0; exception_raise = 1'b0; mem_wait = 1'b0;
  endtask

  initial begin
    idle();
    rst_sync_n = 1'b0;
    tick();
    chk_en = 1'b1;

    // Reset state
    tick(); samp();
    check("rst_flushes", 32'({if_id_flush_1, id_ex_flush_1, ex_mem_flush_1}), 32'h7);
    check("rst_stalls", 32'({pc_stall_n_1, if_id_stall_n_1, id_ex_stall_n_1, ex_mem_stall_n_1}), 32'hF);
    check("rst_pc_src", 32'(pc_src_1), 32'd0);
    check("rst_bubble_cnt", bubble_cnt_1, 32'd0);

    tick(); rst_sync_n = 1'b1; samp();
    check("post_rst_no_flush", 32'({if_id_flush_1, id_ex_flush_1, ex_mem_flush_1}), 32'h0);
    check("post_rst_cnt", bubble_cnt_1, 32'd0);

    // Load-use on rs1
    tick(); ex_is_load = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_rs1_used = 1'b1; samp();
    check("lu_pc_stall_n", 32'(pc_stall_n_1), 32'd0);
    check("lu_if_id_stall_n", 32'(if_id_stall_n_1), 32'd0);
    check("lu_id_ex_flush", 32'(id_ex_flush_1), 32'd1);
    check("lu_back_stalls", 32'({id_ex_stall_n_1, ex_mem_stall_n_1}), 32'h3);

    // Same with x0 as destination: no hazard
    tick(); ex_rd = 5'd0; samp();
    check("lu_x0_pc_stall_n", 32'(pc_stall_n_1), 32'd1);
    check("lu_x0_id_ex_flush", 32'(id_ex_flush_1), 32'd0);

    // rs2 hazard, then the same register unused
    tick(); ex_rd = 5'd7; id_rs1 = 5'd3; id_rs2 = 5'd7; id_rs2_used = 1'b1; samp();
    check("lu_rs2_if_id_stall_n", 32'(if_id_stall_n_1), 32'd0);
    tick(); id_rs2_used = 1'b0; samp();
    check("lu_rs2_unused", 32'(if_id_stall_n_1), 32'd1);

    // Redirect pulse
    tick(); idle(); base = m_cnt[1]; redirect_ex = 1'b1; samp();
    check("redir_c0_pc_src", 32'(pc_src_1), 32'd1);
    check("redir_c0_flushes", 32'({if_id_flush_1, id_ex_flush_1, ex_mem_flush_1}), 32'h6);
    check("redir_c0_pc_src_lat0", 32'(pc_src_0), 32'd1);
    tick(); redirect_ex = 1'b0; samp();
    check("redir_c1_flushes", 32'({if_id_flush_1, id_ex_flush_1, ex_mem_flush_1}), 32'h4);
    check("redir_c1_lat0_no_flush", 32'({if_id_flush_0, id_ex_flush_0, ex_mem_flush_0}), 32'h0);
    tick(); samp();
    check("redir_c2_flushes", 32'({if_id_flush_1, id_ex_flush_1, ex_mem_flush_1}), 32'h0);
    check("redir_bubble_delta", bubble_cnt_1, base + 32'd2);

    // Trap while the data bus waits
    tick(); exception_raise = 1'b1; mem_wait = 1'b1; samp();
    check("trap_pc_src", 32'(pc_src_1), 32'd2);
    check("trap_flushes", 32'({if_id_flush_1, id_ex_flush_1, ex_mem_flush_1}), 32'h7);
    check("trap_stalls", 32'({pc_stall_n_1, if_id_stall_n_1, id_ex_stall_n_1, ex_mem_stall_n_1}), 32'hF);
    tick(); exception_raise = 1'b0; mem_wait = 1'b0; samp();
    check("trap_refill", 32'(if_id_flush_1), 32'd1);

    // mem_wait arriving in REFILL
    tick(); redirect_ex = 1'b1;
    tick(); redirect_ex = 1'b0; mem_wait = 1'b1;
    for (int k = 0; k < 3; k++) begin
      samp();
      check($sformatf("mw_refill_stalls_%0d", k),
            32'({pc_stall_n_1, if_id_stall_n_1, id_ex_stall_n_1, ex_mem_stall_n_1}), 32'h0);
      check($sformatf("mw_refill_flushes_%0d", k),
            32'({if_id_flush_1, id_ex_flush_1, ex_mem_flush_1}), 32'h0);
      tick();
    end
    mem_wait = 1'b0; samp();
    check("mw_refill_resume", 32'({if_id_flush_1, id_ex_flush_1, ex_mem_flush_1}), 32'h4);
    tick(); samp();
    check("mw_refill_done", 32'(if_id_flush_1), 32'd0);

    // Redirect and load-use together
    tick(); redirect_ex = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd9; id_rs1 = 5'd9; id_rs1_used = 1'b1; samp();
    check("both_pc_src", 32'(pc_src_1), 32'd1);
    check("both_stalls", 32'({pc_stall_n_1, if_id_stall_n_1}), 32'h3);
    check("both_flushes", 32'({if_id_flush_1, id_ex_flush_1}), 32'h3);
    tick(); idle(); samp();

    // Reset during REFILL
    tick(); redirect_ex = 1'b1;
    tick(); redirect_ex = 1'b0; rst_sync_n = 1'b0; samp();
    check("rst_refill_flushes_0", 32'({if_id_flush_1, id_ex_flush_1, ex_mem_flush_1}), 32'h7);
    tick(); samp();
    check("rst_refill_flushes_1", 32'({if_id_flush_1, id_ex_flush_1, ex_mem_flush_1}), 32'h7);
    check("rst_refill_cnt", bubble_cnt_1, 32'd0);
    tick(); rst_sync_n = 1'b1; samp();
    check("rst_refill_release_flush", 32'({if_id_flush_1, id_ex_flush_1, ex_mem_flush_1}), 32'h0);
    check("rst_refill_release_pc_src", 32'(pc_src_1), 32'd0);

    // Trap from RUN then mem_wait on the following cycle (latency 1 keeps refill pending)
    tick(); exception_raise = 1'b1; samp();
    tick(); exception_raise = 1'b0; mem_wait = 1'b1; samp();
    tick(); mem_wait = 1'b0; samp();
    check("trap_mw_refill", 32'(if_id_flush_1), 32'd1);
    check("trap_mw_lat0_none", 32'(if_id_flush_0), 32'd0);
    tick(); samp();

    tick();
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
